// File: rtl/opcode_pkg.sv
// Shared opcode encodings, ALU-op classes and the control-strobe bundle
// used by the main control unit.
package opcode_pkg;

  localparam logic [5:0] OP_CODE_RR     = 6'b000000;
  localparam logic [5:0] OP_CODE_REGIMM = 6'b000001;
  localparam logic [5:0] OP_CODE_J      = 6'b000010;
  localparam logic [5:0] OP_CODE_BEQ    = 6'b000100;
  localparam logic [5:0] OP_CODE_BNE    = 6'b000101;
  localparam logic [5:0] OP_CODE_ADDI   = 6'b001000;
  localparam logic [5:0] OP_CODE_ORI    = 6'b001101;
  localparam logic [5:0] OP_CODE_LW     = 6'b100011;
  localparam logic [5:0] OP_CODE_SW     = 6'b101011;

  typedef enum logic [1:0] {
    ALU_ADD   = 2'b00,
    ALU_SUB   = 2'b01,
    ALU_RTYPE = 2'b10,
    ALU_OR    = 2'b11
  } alu_op_t;

  typedef struct packed {
    logic    reg_dst;
    logic    alu_src;
    logic    mem_to_reg;
    logic    reg_wr;
    logic    mem_rd;
    logic    mem_wr;
    logic    branch;
    alu_op_t alu_op;
    logic    jump;
  } ctrl_t;

endpackage

// File: rtl/mcu.sv
// Main control unit: combinational opcode decode into datapath strobes plus
// a sticky flag that records any undefined opcode seen since reset.
module mcu
  import opcode_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] op_code,
  output logic       RegDst,
  output logic       ALUSrc,
  output logic       MemtoReg,
  output logic       RegWr,
  output logic       MemRd,
  output logic       MemWr,
  output logic       Branch,
  output logic       Jump,
  output logic [1:0] ALUOp,
  output logic       illegal_op
);

  ctrl_t ctrl;
  logic  legal;

  always_comb begin
    ctrl  = '0;
    legal = 1'b1;
    case (op_code)
      OP_CODE_RR: begin
        ctrl.reg_dst = 1'b1;
        ctrl.reg_wr  = 1'b1;
        ctrl.alu_op  = ALU_RTYPE;
      end
      OP_CODE_LW: begin
        ctrl.alu_src    = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.reg_wr     = 1'b1;
        ctrl.mem_rd     = 1'b1;
      end
      OP_CODE_SW: begin
        ctrl.alu_src = 1'b1;
        ctrl.mem_wr  = 1'b1;
      end
      // Branch flavours are told apart later from op_code and rt.
      OP_CODE_BEQ, OP_CODE_BNE, OP_CODE_REGIMM: begin
        ctrl.branch = 1'b1;
        ctrl.alu_op = ALU_SUB;
      end
      OP_CODE_J: ctrl.jump = 1'b1;
      OP_CODE_ADDI: begin
        ctrl.alu_src = 1'b1;
        ctrl.reg_wr  = 1'b1;
      end
      OP_CODE_ORI: begin
        ctrl.alu_src = 1'b1;
        ctrl.reg_wr  = 1'b1;
        ctrl.alu_op  = ALU_OR;
      end
      default: legal = 1'b0;
    endcase
  end

  assign RegDst   = ctrl.reg_dst;
  assign ALUSrc   = ctrl.alu_src;
  assign MemtoReg = ctrl.mem_to_reg;
  assign RegWr    = ctrl.reg_wr;
  assign MemRd    = ctrl.mem_rd;
  assign MemWr    = ctrl.mem_wr;
  assign Branch   = ctrl.branch;
  assign Jump     = ctrl.jump;
  assign ALUOp    = ctrl.alu_op;

  // An unknown opcode leaves the flag untouched rather than falsely setting it.
  always_ff @(posedge clk) begin
    if (rst)
      illegal_op <= 1'b0;
    else if (!$isunknown(op_code) && !legal)
      illegal_op <= 1'b1;
  end

endmodule

// File: tb/tb_mcu.sv
// Directed self-checking bench for the main control unit decode table,
// sticky illegal-opcode flag and decode invariants.
module tb_mcu;
  import opcode_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] op_code;
  logic       RegDst, ALUSrc, MemtoReg, RegWr, MemRd, MemWr, Branch, Jump;
  logic [1:0] ALUOp;
  logic       illegal_op;
  logic [9:0] dec;

  int errors = 0;
  int checks = 0;

  mcu dut (
    .clk        (clk),
    .rst        (rst),
    .op_code    (op_code),
    .RegDst     (RegDst),
    .ALUSrc     (ALUSrc),
    .MemtoReg   (MemtoReg),
    .RegWr      (RegWr),
    .MemRd      (MemRd),
    .MemWr      (MemWr),
    .Branch     (Branch),
    .Jump       (Jump),
    .ALUOp      (ALUOp),
    .illegal_op (illegal_op)
  );

  always #5 clk = ~clk;

  // Same field order as the decode table: RegDst ALUSrc MemtoReg RegWr MemRd MemWr Branch ALUOp Jump
  assign dec = {RegDst, ALUSrc, MemtoReg, RegWr, MemRd, MemWr, Branch, ALUOp, Jump};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_dec(input string tag, input logic [5:0] op, input logic [9:0] exp);
    op_code = op;
    #10;
    check(tag, 32'(dec), 32'(exp));
  endtask

  initial begin
    int nonzero;
    int viol;

    rst     = 1'b1;
    op_code = OP_CODE_RR;
    @(posedge clk); #1;
    check("reset_illegal", 32'(illegal_op), 32'd0);
    check("reset_rr_dec", 32'(dec), 32'(10'b1001000100));
    rst = 1'b0;

    check_dec("dec_rr",     6'b000000, 10'b1001000100);
    check_dec("dec_lw",     6'b100011, 10'b0111100000);
    check_dec("dec_sw",     6'b101011, 10'b0100010000);
    check_dec("dec_beq",    6'b000100, 10'b0000001010);
    check_dec("dec_bne",    6'b000101, 10'b0000001010);
    check_dec("dec_regimm", 6'b000001, 10'b0000001010);
    check_dec("dec_j",      6'b000010, 10'b0000000001);
    check_dec("dec_addi",   6'b001000, 10'b0101000000);
    check_dec("dec_ori",    6'b001101, 10'b0101000110);
    check("legal_sweep_no_flag", 32'(illegal_op), 32'd0);

    @(negedge clk);
    op_code = 6'b111111;
    #1;
    check("dec_illegal_zero", 32'(dec), 32'd0);
    check("illegal_before_edge", 32'(illegal_op), 32'd0);
    @(posedge clk); #1;
    check("illegal_set", 32'(illegal_op), 32'd1);
    op_code = OP_CODE_ADDI;
    @(posedge clk); #1;
    check("illegal_sticky", 32'(illegal_op), 32'd1);

    rst     = 1'b1;
    op_code = 6'b111111;
    @(posedge clk); #1;
    check("reset_wins", 32'(illegal_op), 32'd0);
    rst     = 1'b0;
    op_code = OP_CODE_RR;
    @(posedge clk); #1;
    check("post_reset_illegal", 32'(illegal_op), 32'd0);
    check("post_reset_regdst", 32'(RegDst), 32'd1);
    check("post_reset_regwr", 32'(RegWr), 32'd1);
    check("post_reset_aluop", 32'(ALUOp), 32'(2'b10));

    op_code = 6'bxxxxxx;
    @(posedge clk); #1;
    check("x_opcode_hold", 32'(illegal_op), 32'd0);
    op_code = OP_CODE_RR;

    nonzero = 0;
    viol    = 0;
    for (int i = 0; i < 64; i++) begin
      op_code = 6'(i);
      #1;
      if (dec != 10'd0) nonzero++;
      if (MemRd && MemWr) viol++;
      if (RegWr && (Branch || Jump)) viol++;
    end
    check("sweep_nonzero_count", 32'(nonzero), 32'd9);
    check("sweep_invariants", 32'(viol), 32'd0);

    rst = 1'b1;
    @(posedge clk); #2;
    rst     = 1'b0;
    op_code = OP_CODE_ORI;
    #1;
    check("mid_ori_aluop", 32'(ALUOp), 32'(2'b11));
    check("mid_ori_jump", 32'(Jump), 32'd0);
    op_code = OP_CODE_J;
    #1;
    check("mid_j_aluop", 32'(ALUOp), 32'(2'b00));
    check("mid_j_jump", 32'(Jump), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
